logic_lane_acc: RTL and testbench
=================================

LOGIC_LANE_ACC -- requirements
Module: logic_lane_acc

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high: ib_clk is the clock, ib_rst the reset.
REQ-002 Parameter PAR_DATA_BITS, default 8, SHALL set the total data width.
REQ-003 Parameter PAR_LANES, default 2, SHALL set the lane count; PAR_DATA_BITS SHALL be divisible by PAR_LANES; lane width W = PAR_DATA_BITS/PAR_LANES.
REQ-004 Parameter PAR_ACC_LEN, default 4, range >= 1, SHALL set the number of samples per frame.
REQ-005 Parameter PAR_SAT, default 0, SHALL select per-lane wrap (0) or saturate (1) arithmetic.
REQ-006 Ports SHALL be (name  direction  width  meaning):
- ib_clk  in  1  clock
- ib_rst  in  1  synchronous active-high reset
- ib_valid  in  1  input sample valid
- ob_ready  out  1  block accepts a sample
- ivG_data  in  PAR_DATA_BITS  input sample
- ib_clear  in  1  abort current frame
- ob_valid  out  1  frame result valid
- ib_ready  in  1  downstream accepts result
- ovG_data  out  PAR_DATA_BITS  mixed result
- ovG_sum  out  PAR_DATA_BITS  raw per-lane sums
- ob_ovf  out  1  any lane overflowed during frame

Function
REQ-007 Lane k SHALL be bits [k*W +: W]; each lane SHALL accumulate its own slice, with no carry between lanes.
REQ-008 In wrap mode, a lane sum SHALL be modulo 2^W; in saturate mode it SHALL clamp at 2^W-1.
REQ-009 A lane overflow (carry out in wrap mode, clamp in saturate mode) SHALL set a sticky frame flag, cleared only at frame end, clear or reset.
REQ-010 The FSM SHALL have two states: S_ACC (ob_ready=1, ob_valid=0) and S_OUT (ob_ready=0, ob_valid=1).
REQ-011 A sample SHALL be accepted only when ib_valid=1 in S_ACC; a frame counter SHALL increment per accepted sample.
REQ-012 Acceptance of sample PAR_ACC_LEN-1 in cycle N SHALL enter S_OUT in cycle N+1, with results including that sample.
REQ-013 In S_OUT, ovG_sum SHALL present the lane sums, ob_ovf the sticky flag, and ovG_data lane k SHALL equal sum[k] XOR sum[(k+1) mod PAR_LANES]; for PAR_LANES=1, ovG_data SHALL equal ovG_sum.
REQ-014 All outputs SHALL be registered and held stable while ob_valid=1 and ib_ready=0; ib_valid SHALL be ignored in S_OUT.
REQ-015 When ob_valid=1 and ib_ready=1, the next cycle SHALL be S_ACC with the accumulators, counter and flag zeroed.
REQ-016 ib_clear=1 in any state SHALL give, in the next cycle, S_ACC with the accumulators, counter and flag zeroed; a sample presented in the same cycle SHALL be discarded.
REQ-017 Priority SHALL be ib_rst > ib_clear > handshake/accumulate.
REQ-018 Outside S_OUT, ovG_data, ovG_sum and ob_ovf SHALL be 0.

Reset
REQ-019 While ib_rst=1, the block SHALL drive ob_ready=0, ob_valid=0, and ovG_data, ovG_sum and ob_ovf to 0, and SHALL ignore all inputs.
REQ-020 The cycle after ib_rst deasserts SHALL be S_ACC with ob_ready=1; reset in the middle of a frame or in S_OUT SHALL discard all partial or pending results.

Verification
REQ-021 Defaults (wrap mode), samples 0x12, 0x34, 0x56, 0x78 -> 1 cycle after the last sample: ob_valid=1, ovG_sum=0x04, ovG_data=0x44, ob_ovf=1.
REQ-022 PAR_SAT=1, same samples -> ovG_sum=0xFF, ovG_data=0x00, ob_ovf=1.
REQ-023 ib_ready held 0 for 3 cycles in S_OUT, with ib_valid=1 throughout -> outputs constant, ob_ready=0, no sample counted; ib_ready=1 -> ob_valid=0 and ob_ready=1 next cycle.
REQ-024 Two samples, then ib_clear, then four samples of 0x01 -> ovG_sum=0x04, ovG_data=0x44, ob_ovf=0.
REQ-025 PAR_DATA_BITS=16, PAR_LANES=4, PAR_ACC_LEN=1, sample 0x1234 -> next cycle ob_valid=1, ovG_sum=0x1234, ovG_data=0x5317.
REQ-026 ib_rst pulsed during S_OUT -> next cycle all outputs 0; the cycle after release has ob_ready=1, and a fresh frame gives the REQ-021 result.

Source files
------------

// File: rtl/logic_lane_acc.sv
`default_nettype none
// ============================================================================
//  Module   : logic_lane_acc
//  Purpose  : Per-lane frame accumulator. Each W-bit lane of the input sample
//             is summed independently (wrap or saturate) over PAR_ACC_LEN
//             accepted samples. The frame result is then held with a
//             valid/ready handshake, together with a lane-mixed XOR view and
//             a sticky overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module logic_lane_acc #(
  parameter int PAR_DATA_BITS = 8,
  parameter int PAR_LANES     = 2,
  parameter int PAR_ACC_LEN   = 4,
  parameter int PAR_SAT       = 0
) (
  input  logic                     ib_clk,
  input  logic                     ib_rst,
  input  logic                     ib_valid,
  output logic                     ob_ready,
  input  logic [PAR_DATA_BITS-1:0] ivG_data,
  input  logic                     ib_clear,
  output logic                     ob_valid,
  input  logic                     ib_ready,
  output logic [PAR_DATA_BITS-1:0] ovG_data,
  output logic [PAR_DATA_BITS-1:0] ovG_sum,
  output logic                     ob_ovf
);

  localparam int LW = PAR_DATA_BITS / PAR_LANES;
  localparam int CW = (PAR_ACC_LEN > 1) ? $clog2(PAR_ACC_LEN) : 1;

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic                       ready_q, valid_q;
  logic                       accept, handshake, last;

  logic [CW-1:0]              cnt_q;
  logic [PAR_DATA_BITS-1:0]   acc_q, acc_d;
  logic [PAR_DATA_BITS-1:0]   mix_d;
  logic [PAR_LANES-1:0]       lane_ovf;
  logic                       ovf_q, ovf_d;

  logic [PAR_DATA_BITS-1:0]   sum_o_q, data_o_q;
  logic                       ovf_o_q;

  // The sample being accepted now is the final one of the frame.
  assign last  = (cnt_q == CW'(PAR_ACC_LEN - 1));
  assign ovf_d = ovf_q | (|lane_ovf);

  // Independent lane adders; the extra top bit is the lane carry.
  for (genvar k = 0; k < PAR_LANES; k++) begin : g_lane
    logic [LW:0] raw;
    assign raw         = {1'b0, acc_q[k*LW +: LW]} + {1'b0, ivG_data[k*LW +: LW]};
    assign lane_ovf[k] = raw[LW];
    if (PAR_SAT != 0) begin : g_sat
      assign acc_d[k*LW +: LW] = raw[LW] ? {LW{1'b1}} : raw[LW-1:0];
    end else begin : g_wrap
      assign acc_d[k*LW +: LW] = raw[LW-1:0];
    end
  end

  // Lane k of the mixed result folds in its upper neighbour (cyclically).
  if (PAR_LANES == 1) begin : g_mix_one
    assign mix_d = acc_d;
  end else begin : g_mix
    for (genvar k = 0; k < PAR_LANES; k++) begin : g_mix_lane
      assign mix_d[k*LW +: LW] = acc_d[k*LW +: LW]
                               ^ acc_d[((k + 1) % PAR_LANES)*LW +: LW];
    end
  end

  // State register plus registered handshake outputs derived from next state.
  always_ff @(posedge ib_clk) begin
    if (ib_rst) begin
      state_q <= S_ACC;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_ACC);
      valid_q <= (state_d == S_OUT);
    end
  end

  // Next-state and strobes; clear overrides both acceptance and handshake.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    handshake = 1'b0;
    case (state_q)
      S_ACC: begin
        if (ib_valid) begin
          accept = 1'b1;
          if (last) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (ib_ready) begin
          handshake = 1'b1;
          state_d   = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
    if (ib_clear) begin
      state_d   = S_ACC;
      accept    = 1'b0;
      handshake = 1'b0;
    end
  end

  // Accumulators, frame counter, sticky flag and held result registers.
  always_ff @(posedge ib_clk) begin
    if (ib_rst || ib_clear || handshake) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      sum_o_q  <= '0;
      data_o_q <= '0;
      ovf_o_q  <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= last ? '0 : cnt_q + CW'(1);
      if (last) begin
        sum_o_q  <= acc_d;
        data_o_q <= mix_d;
        ovf_o_q  <= ovf_d;
      end
    end
  end

  assign ob_ready = ready_q;
  assign ob_valid = valid_q;
  assign ovG_sum  = sum_o_q;
  assign ovG_data = data_o_q;
  assign ob_ovf   = ovf_o_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_lane_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_lane_acc
//  Purpose  : Self-checking bench for logic_lane_acc. Three configurations
//             (wrap 8/2/4, saturate 8/2/4, wrap 16/4/1) share control inputs
//             and are compared each cycle against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_lane_acc;

  logic        clk;
  logic        rst, valid, clr, rdy;
  logic [7:0]  d8;
  logic [15:0] d16;

  logic        rdy0, rdy1, rdy2, val0, val1, val2, ovf0, ovf1, ovf2;
  logic [7:0]  sum0, sum1, dat0, dat1;
  logic [15:0] sum2, dat2;

  logic_lane_acc #(.PAR_DATA_BITS(8), .PAR_LANES(2), .PAR_ACC_LEN(4), .PAR_SAT(0)) dut0 (
    .ib_clk(clk), .ib_rst(rst), .ib_valid(valid), .ob_ready(rdy0), .ivG_data(d8),
    .ib_clear(clr), .ob_valid(val0), .ib_ready(rdy), .ovG_data(dat0), .ovG_sum(sum0),
    .ob_ovf(ovf0));

  logic_lane_acc #(.PAR_DATA_BITS(8), .PAR_LANES(2), .PAR_ACC_LEN(4), .PAR_SAT(1)) dut1 (
    .ib_clk(clk), .ib_rst(rst), .ib_valid(valid), .ob_ready(rdy1), .ivG_data(d8),
    .ib_clear(clr), .ob_valid(val1), .ib_ready(rdy), .ovG_data(dat1), .ovG_sum(sum1),
    .ob_ovf(ovf1));

  logic_lane_acc #(.PAR_DATA_BITS(16), .PAR_LANES(4), .PAR_ACC_LEN(1), .PAR_SAT(0)) dut2 (
    .ib_clk(clk), .ib_rst(rst), .ib_valid(valid), .ob_ready(rdy2), .ivG_data(d16),
    .ib_clear(clr), .ob_valid(val2), .ib_ready(rdy), .ovG_data(dat2), .ovG_sum(sum2),
    .ob_ovf(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- frame-level reference model ----------------
  // All lanes are 4 bits wide in the three configurations.
  localparam int ML[3]   = '{2, 2, 4};
  localparam int MLEN[3] = '{4, 4, 1};
  localparam int MSAT[3] = '{0, 1, 0};

  int          mst [3];
  int          mcnt[3];
  int          mtot[3][4];
  bit          m_rst;
  bit          started = 1'b0;
  logic        e_ready[3], e_valid[3], e_ovf[3];
  logic [15:0] e_sum[3], e_data[3];
  logic [15:0] m_din;
  int          m_s[4];

  always @(posedge clk) begin
    m_rst = rst;
    for (int i = 0; i < 3; i++) begin
      m_din = (i == 2) ? d16 : {8'h00, d8};
      if (rst || clr) begin
        mst[i] = 0; mcnt[i] = 0;
        for (int k = 0; k < 4; k++) mtot[i][k] = 0;
      end else if (mst[i] == 0) begin
        if (valid) begin
          for (int k = 0; k < ML[i]; k++) mtot[i][k] += int'((m_din >> (4*k)) & 16'hF);
          mcnt[i]++;
          if (mcnt[i] == MLEN[i]) mst[i] = 1;
        end
      end else if (rdy) begin
        mst[i] = 0; mcnt[i] = 0;
        for (int k = 0; k < 4; k++) mtot[i][k] = 0;
      end
      // Expected outputs: true sum exceeding 15 means the lane overflowed.
      e_ready[i] = !m_rst && (mst[i] == 0);
      e_valid[i] = !m_rst && (mst[i] == 1);
      e_sum[i] = 16'h0; e_data[i] = 16'h0; e_ovf[i] = 1'b0;
      if (mst[i] == 1) begin
        for (int k = 0; k < ML[i]; k++) begin
          if (mtot[i][k] > 15) e_ovf[i] = 1'b1;
          m_s[k] = (MSAT[i] != 0) ? ((mtot[i][k] > 15) ? 15 : mtot[i][k]) : (mtot[i][k] % 16);
          e_sum[i] |= 16'(m_s[k] << (4*k));
        end
        for (int k = 0; k < ML[i]; k++)
          e_data[i] |= 16'((m_s[k] ^ m_s[(k+1) % ML[i]]) << (4*k));
      end
    end
    started = 1'b1;
  end

  // Cycle-by-cycle comparison of every output of every instance.
  always @(negedge clk) begin
    if (started) begin
      check("i0 ready", {15'h0, rdy0}, {15'h0, e_ready[0]});
      check("i0 valid", {15'h0, val0}, {15'h0, e_valid[0]});
      check("i0 sum",   {8'h0, sum0},  e_sum[0]);
      check("i0 data",  {8'h0, dat0},  e_data[0]);
      check("i0 ovf",   {15'h0, ovf0}, {15'h0, e_ovf[0]});
      check("i1 ready", {15'h0, rdy1}, {15'h0, e_ready[1]});
      check("i1 valid", {15'h0, val1}, {15'h0, e_valid[1]});
      check("i1 sum",   {8'h0, sum1},  e_sum[1]);
      check("i1 data",  {8'h0, dat1},  e_data[1]);
      check("i1 ovf",   {15'h0, ovf1}, {15'h0, e_ovf[1]});
      check("i2 ready", {15'h0, rdy2}, {15'h0, e_ready[2]});
      check("i2 valid", {15'h0, val2}, {15'h0, e_valid[2]});
      check("i2 sum",   sum2,          e_sum[2]);
      check("i2 data",  dat2,          e_data[2]);
      check("i2 ovf",   {15'h0, ovf2}, {15'h0, e_ovf[2]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] smp[4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  task automatic feed_frame();
    for (int i = 0; i < 4; i++) begin
      d8 = smp[i]; valid = 1'b1;
      tick();
    end
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; clr = 1'b0; rdy = 1'b0; d8 = 8'h0; d16 = 16'h0;
    repeat (3) tick();
    check("rst ready", {15'h0, rdy0}, 16'h0);
    check("rst valid", {15'h0, val0}, 16'h0);
    check("rst sum",   {8'h0, sum0},  16'h0);
    rst = 1'b0;
    tick();
    check("post-rst ready", {15'h0, rdy0}, 16'h1);

    // Basic frame; the 16-bit single-sample instance completes on sample 0.
    for (int i = 0; i < 4; i++) begin
      d8 = smp[i]; d16 = (i == 0) ? 16'h1234 : 16'h1111; valid = 1'b1;
      tick();
      if (i == 0) begin
        check("w16 valid", {15'h0, val2}, 16'h1);
        check("w16 sum",   sum2, 16'h1234);
        check("w16 data",  dat2, 16'h5317);
      end
    end
    check("wrap valid", {15'h0, val0}, 16'h1);
    check("wrap sum",   {8'h0, sum0},  16'h0004);
    check("wrap data",  {8'h0, dat0},  16'h0044);
    check("wrap ovf",   {15'h0, ovf0}, 16'h1);
    check("sat sum",    {8'h0, sum1},  16'h00FF);
    check("sat data",   {8'h0, dat1},  16'h0000);
    check("sat ovf",    {15'h0, ovf1}, 16'h1);

    // Back-pressure: result held, input samples ignored.
    d8 = 8'h55; valid = 1'b1; rdy = 1'b0;
    repeat (3) begin
      tick();
      check("hold sum",   {8'h0, sum0}, 16'h0004);
      check("hold data",  {8'h0, dat0}, 16'h0044);
      check("hold ready", {15'h0, rdy0}, 16'h0);
      check("hold valid", {15'h0, val0}, 16'h1);
    end
    rdy = 1'b1;
    tick();
    check("release valid", {15'h0, val0}, 16'h0);
    check("release ready", {15'h0, rdy0}, 16'h1);
    rdy = 1'b0; valid = 1'b0;

    // Partial frame aborted by clear, then a clean frame of ones.
    d8 = 8'h33; valid = 1'b1;
    repeat (2) tick();
    valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; d8 = 8'h01; valid = 1'b1;
    repeat (4) tick();
    valid = 1'b0;
    check("clear valid", {15'h0, val0}, 16'h1);
    check("clear sum",   {8'h0, sum0},  16'h0004);
    check("clear data",  {8'h0, dat0},  16'h0044);
    check("clear ovf",   {15'h0, ovf0}, 16'h0);

    // Reset while a result is pending.
    rst = 1'b1;
    tick();
    check("rst-out valid", {15'h0, val0}, 16'h0);
    check("rst-out ready", {15'h0, rdy0}, 16'h0);
    check("rst-out sum",   {8'h0, sum0},  16'h0);
    check("rst-out data",  {8'h0, dat0},  16'h0);
    check("rst-out ovf",   {15'h0, ovf0}, 16'h0);
    rst = 1'b0;
    tick();
    check("rst-rel ready", {15'h0, rdy0}, 16'h1);
    feed_frame();
    check("fresh sum",  {8'h0, sum0},  16'h0004);
    check("fresh data", {8'h0, dat0},  16'h0044);
    check("fresh ovf",  {15'h0, ovf0}, 16'h1);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;

    // Randomised traffic against the model.
    repeat (3000) begin
      rst   = ($urandom_range(0, 99) == 0);
      clr   = ($urandom_range(0, 29) == 0);
      valid = ($urandom_range(0, 9) < 7);
      rdy   = ($urandom_range(0, 1) == 1);
      d8    = 8'($urandom);
      d16   = 16'($urandom);
      tick();
    end
    rst = 1'b0; clr = 1'b0; valid = 1'b0; rdy = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
